// File: rtl/lf_edge_period_capture.sv
`default_nettype none
// ============================================================================
// Module   : lf_edge_period_capture
// Brief    : Measures clk-cycle intervals between LF edge transitions and
//            queues {level, sat, count} words in a small FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module lf_edge_period_capture #(
    parameter int CNT_W   = 14,
    parameter int FIFO_AW = 3,
    parameter int MIN_LEN = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               edge_in,
    output logic [CNT_W+1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [FIFO_AW:0]   fifo_count,
    output logic               overflow
);

    localparam int                c_depth   = 1 << FIFO_AW;
    localparam logic [CNT_W-1:0]  c_min_len = CNT_W'(MIN_LEN);
    localparam logic [CNT_W-1:0]  c_max_cnt = '1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARM     = 2'd1,
        S_MEASURE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic                 r_edge_q;
    logic                 r_edge_qq;
    logic [CNT_W-1:0]     r_count;
    logic                 r_sat;
    logic                 r_level;
    logic [CNT_W+1:0]     r_mem [c_depth];
    logic [FIFO_AW-1:0]   r_wr_ptr;
    logic [FIFO_AW-1:0]   r_rd_ptr;
    logic [FIFO_AW:0]     r_fill;
    logic                 r_overflow;

    logic w_trans;
    logic w_push;
    logic w_pop;
    logic w_full;
    logic w_wr;
    logic w_arm_entry;

    assign w_trans     = r_edge_q ^ r_edge_qq;
    assign w_push      = (r_state == S_MEASURE) && en && w_trans && (r_count >= c_min_len);
    assign w_pop       = out_valid && out_ready;
    // Fill count reaches exactly c_depth only when its top bit is set
    assign w_full      = r_fill[FIFO_AW];
    assign w_wr        = w_push && (!w_full || w_pop);
    assign w_arm_entry = (r_state == S_IDLE) && en;

    assign out_valid  = (r_fill != '0);
    assign out_data   = out_valid ? r_mem[r_rd_ptr] : '0;
    assign fifo_count = r_fill;
    assign overflow   = r_overflow;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (en) w_next = S_ARM;
            S_ARM:     if (!en) w_next = S_IDLE;
                       else if (w_trans) w_next = S_MEASURE;
            S_MEASURE: if (!en) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Interval measurement; a transition closes the current interval whether
    // or not it was long enough to be recorded.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_edge_q  <= 1'b0;
            r_edge_qq <= 1'b0;
            r_count   <= '0;
            r_sat     <= 1'b0;
            r_level   <= 1'b0;
        end else begin
            r_edge_q  <= edge_in;
            r_edge_qq <= r_edge_q;
            if (en && w_trans && (r_state == S_ARM || r_state == S_MEASURE)) begin
                r_count <= CNT_W'(1);
                r_sat   <= 1'b0;
                r_level <= r_edge_q;
            end else if (en && r_state == S_MEASURE) begin
                if (r_count == c_max_cnt) r_sat <= 1'b1;
                else                      r_count <= r_count + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_wr) r_mem[r_wr_ptr] <= {r_level, r_sat, r_count};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fill     <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr)  r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
            case ({w_wr, w_pop})
                2'b10:   r_fill <= r_fill + (FIFO_AW+1)'(1);
                2'b01:   r_fill <= r_fill - (FIFO_AW+1)'(1);
                default: r_fill <= r_fill;
            endcase
            if (w_arm_entry)                    r_overflow <= 1'b0;
            else if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lf_edge_period_capture.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_lf_edge_period_capture
// Brief    : Directed scoreboard bench for lf_edge_period_capture.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lf_edge_period_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        edge_in;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  fifo_count;
    logic        overflow;

    int n_asserts = 0;
    int n_fail    = 0;
    logic [15:0] exp_q[$];

    lf_edge_period_capture #(.CNT_W(14), .FIFO_AW(3), .MIN_LEN(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .edge_in    (edge_in),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic exp_push(input logic lvl, input logic sat, input int n);
        exp_q.push_back({lvl, sat, 14'(n)});
    endtask

    // Hold edge_in at lvl for n cycles; the word for this interval is
    // emitted when the next interval starts.
    task automatic interval(input logic lvl, input int n, input bit rec);
        edge_in = lvl;
        tick(n);
        if (rec) exp_push(lvl, 1'b0, n);
    endtask

    task automatic drain(input int maxc);
        int c = 0;
        while (exp_q.size() != 0 && c < maxc) begin
            tick();
            c++;
        end
        n_asserts++;
        assert (exp_q.size() == 0) else begin
            n_fail++;
            $error("FAIL drain_timeout observed=%0d expected=0 words outstanding", exp_q.size());
        end
    endtask

    task automatic do_reset();
        en      = 1'b0;
        edge_in = 1'b0;
        rst     = 1'b1;
        tick();
        rst     = 1'b0;
        exp_q.delete();
        tick(3);
    endtask

    // Consumer side: every accepted head word must match the scoreboard
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_asserts++;
            assert (exp_q.size() != 0) else begin
                n_fail++;
                $error("FAIL word_unexpected observed=%0h expected=none", out_data);
            end
            if (exp_q.size() != 0) check("word", {16'h0, out_data}, {16'h0, exp_q.pop_front()});
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; en = 1'b0; edge_in = 1'b0; out_ready = 1'b0;
        tick(3);
        check("rst_valid", out_valid, 0);
        check("rst_fill", fifo_count, 0);
        check("rst_ovf", overflow, 0);
        check("rst_data", out_data, 0);
        rst = 1'b0;
        tick();
        check("post_rst_data", out_data, 0);

        // Square wave 10/10: first half-period discarded
        do_reset();
        out_ready = 1'b1;
        en = 1'b1;
        tick(3);
        interval(1'b1, 10, 1'b1);
        edge_in = 1'b0;
        tick();
        check("valid_early", out_valid, 0);
        tick();
        check("valid_rise", out_valid, 1);
        tick(8);
        exp_push(1'b0, 1'b0, 10);
        interval(1'b1, 10, 1'b1);
        interval(1'b0, 10, 1'b1);
        edge_in = 1'b1;
        tick(5);
        drain(20);

        // Glitch discard plus MIN_LEN boundary
        do_reset();
        en = 1'b1;
        tick(3);
        interval(1'b1, 4, 1'b1);
        interval(1'b0, 20, 1'b1);
        interval(1'b1, 3, 1'b0);
        interval(1'b0, 20, 1'b1);
        edge_in = 1'b1;
        tick(5);
        drain(20);

        // Saturation
        do_reset();
        en = 1'b1;
        tick(3);
        interval(1'b1, 5, 1'b1);
        edge_in = 1'b0;
        tick(20000);
        exp_q.push_back(16'h7FFF);
        edge_in = 1'b1;
        tick(5);
        drain(20);

        // Full FIFO with coincident push and pop
        do_reset();
        out_ready = 1'b0;
        en = 1'b1;
        tick(3);
        for (int k = 0; k < 9; k++) interval(~k[0], 6, 1'b1);
        check("full_fill", fifo_count, 8);
        check("full_ovf", overflow, 0);
        edge_in = 1'b0;
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("pushpop_fill", fifo_count, 8);
        check("pushpop_ovf", overflow, 0);
        tick(4);
        out_ready = 1'b1;
        drain(30);

        // Overflow with backpressure, then reset mid-measure at fill 5
        do_reset();
        out_ready = 1'b0;
        en = 1'b1;
        tick(3);
        for (int k = 0; k < 10; k++) interval(~k[0], 5 + k, k < 8);
        edge_in = 1'b1;
        tick(3);
        check("ovf_fill", fifo_count, 8);
        check("ovf_set", overflow, 1);
        out_ready = 1'b1;
        tick(20);
        exp_push(1'b1, 1'b0, 23);
        check("ovf_drained", fifo_count, 0);
        check("ovf_sticky", overflow, 1);
        out_ready = 1'b0;
        for (int k = 11; k < 15; k++) interval(~k[0], 5, 1'b1);
        edge_in = 1'b0;
        tick(3);
        check("mid_fill", fifo_count, 5);
        check("mid_valid", out_valid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        check("mid_rst_fill", fifo_count, 0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_ovf", overflow, 0);
        check("mid_rst_data", out_data, 0);
        tick(5);
        check("idle_no_push", fifo_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lf_edge_period_capture.md
LF_EDGE_PERIOD_CAPTURE -- requirements
Module: lf_edge_period_capture

Interface
REQ-001 Parameter CNT_W, default 14: width of the interval count field.
REQ-002 Parameter FIFO_AW, default 3: FIFO address width, giving depth 2^FIFO_AW = 8.
REQ-003 Parameter MIN_LEN, default 4: shortest interval, in clk cycles, that is recorded.
REQ-004 Port clk, input, 1: sole clock, pck0 domain.
REQ-005 Port rst, input, 1: reset, synchronous to clk and active-high.
REQ-006 Port en, input, 1: capture enable.
REQ-007 Port edge_in, input, 1: edge_state or edge_toggle from the LF edge detector, synchronous to clk.
REQ-008 Port out_data, output, CNT_W+2: FIFO head word as {level, sat, count[CNT_W-1:0]}.
REQ-009 Port out_valid, output, 1: FIFO not empty.
REQ-010 Port out_ready, input, 1: consumer accepts the head word.
REQ-011 Port fifo_count, output, FIFO_AW+1: number of words held, 0 to 8.
REQ-012 Port overflow, output, 1: sticky flag, set when a word is dropped.

Function
REQ-013 The block shall register edge_in into edge_q and then edge_qq on every clk, and shall define a transition as edge_q != edge_qq.
REQ-014 The state machine shall have three states: IDLE, ARM and MEASURE.
REQ-015 IDLE shall move to ARM when en=1; ARM and MEASURE shall move to IDLE when en=0, and en=0 shall take priority over a transition in the same cycle.
REQ-016 In ARM, the block shall discard the partial first interval; on a transition it shall load count=1, load level=edge_q and move to MEASURE.
REQ-017 In MEASURE with no transition, the block shall increment count, saturating at 2^CNT_W-1, and shall set sat once saturation is reached.
REQ-018 In MEASURE on a transition with count >= MIN_LEN, the block shall push {level, sat, count}, then reload count=1, sat=0 and level=edge_q.
REQ-019 In MEASURE on a transition with count < MIN_LEN, the block shall push nothing and shall reload exactly as in REQ-018 (glitch discard).
REQ-020 The level field shall hold the edge_q value during the interval just ended.
REQ-021 The count field shall equal the number of clk cycles between two consecutive detected transitions.
REQ-022 A pushed word shall appear at the FIFO head, with out_valid high, one clk after the push cycle when the FIFO was empty.
REQ-023 out_data shall be valid and stable whenever out_valid=1 and shall change only after a pop.
REQ-024 A pop shall occur when out_valid=1 and out_ready=1; out_ready while the FIFO is empty shall have no effect.
REQ-025 A push while the FIFO is full and no pop occurs shall drop the word, set overflow and leave the FIFO unchanged.
REQ-026 A simultaneous push and pop while full shall accept both, leave fifo_count at 8 and leave overflow unchanged.
REQ-027 A simultaneous push and pop at any other fill level shall leave fifo_count unchanged.
REQ-028 Read and write pointers shall wrap modulo 2^FIFO_AW.
REQ-029 overflow shall clear only on rst or on the IDLE to ARM transition.
REQ-030 FIFO contents shall be retained when en=0 and shall remain poppable.

Reset
REQ-031 On rst=1 at a clk edge, the block shall enter IDLE, clear edge_q, edge_qq, count, sat, level and both FIFO pointers, and force out_valid=0, fifo_count=0 and overflow=0.
REQ-032 After rst, out_data shall read 0 until the first push.
REQ-033 A rst asserted mid-interval or mid-pop shall discard all state, with no partial word pushed.
REQ-034 rst shall take priority over en, over a push and over a pop in the same cycle.

Verification
REQ-035 Scenario: en=1, edge_in square wave of 10 cycles high and 10 cycles low -> the first half-period is discarded, then words 0x800A and 0x000A alternate, and out_valid rises 2 clk after the second sampled edge.
REQ-036 Scenario: in MEASURE, a 3-cycle pulse inside 20-cycle low periods -> no word is pushed for the 3-cycle pulse, and the next word has count = cycles since the end of the pulse.
REQ-037 Scenario: in MEASURE, edge_in held 20000 cycles -> the word has sat=1 and count=0x3FFF.
REQ-038 Scenario: out_ready=0 with 10 valid intervals -> fifo_count=8, overflow=1, and the first 8 words drain in order.
REQ-039 Scenario: FIFO full, push coincides with out_ready=1 -> fifo_count stays 8, overflow stays 0, and word order is preserved.
REQ-040 Scenario: rst pulsed while fifo_count=5 and in MEASURE -> on the next cycle state is IDLE, fifo_count=0, out_valid=0 and overflow=0.
